// File: rtl/soc_pkg.sv
`default_nettype none
// soc_pkg: shared boot-loader state encoding and default framing bytes.
package soc_pkg;

   typedef enum logic [2:0] {
      BootIdle   = 3'd0,
      BootHeader = 3'd1,
      BootData   = 3'd2,
      BootCheck  = 3'd3,
      BootAck    = 3'd4,
      BootFail   = 3'd5,
      BootDone   = 3'd6
   } BootState;

   localparam logic [7:0] BOOT_SYNC_DEFAULT = 8'hA5;
   localparam logic [7:0] BOOT_ACK_DEFAULT  = 8'h4B;
   localparam logic [7:0] BOOT_NAK_DEFAULT  = 8'h45;

endpackage
`default_nettype wire

// File: rtl/boot_word_packer.sv
`default_nettype none
// boot_word_packer: packs bytes into little-endian words with lane masks and
// drives the RAM write port with an auto-incrementing word address.
module boot_word_packer #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  load_addr,
   input  logic [ADDR_WIDTH-1:0] base_word,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   input  logic [1:0]            lane,
   input  logic                  last,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   output logic [3:0]            ram_wmask
);

   logic [31:0] word_buf;
   logic [31:0] word_next;
   logic [3:0]  mask_buf;
   logic [3:0]  mask_next;

   always_comb begin
      word_next = word_buf;
      case (lane)
         2'd0:    word_next[7:0]   = byte_data;
         2'd1:    word_next[15:8]  = byte_data;
         2'd2:    word_next[23:16] = byte_data;
         default: word_next[31:24] = byte_data;
      endcase
      mask_next = mask_buf | (4'b0001 << lane);
   end

   // The completed word moves to the output registers immediately, so a byte
   // arriving during the write cycle lands in an already-cleared buffer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         word_buf  <= '0;
         mask_buf  <= '0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_wmask <= '0;
      end else begin
         ram_we <= 1'b0;
         if (load_addr) begin
            ram_addr <= base_word;
         end else if (ram_we) begin
            ram_addr <= ram_addr + ADDR_WIDTH'(1);
         end
         if (start) begin
            word_buf <= '0;
            mask_buf <= '0;
         end else if (byte_valid) begin
            if (lane == 2'd3 || last) begin
               ram_we    <= 1'b1;
               ram_wdata <= word_next;
               ram_wmask <= mask_next;
               word_buf  <= '0;
               mask_buf  <= '0;
            end else begin
               word_buf <= word_next;
               mask_buf <= mask_next;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// uart_boot_loader: receives a framed firmware image over UART, writes it to
// RAM, verifies an 8-bit checksum, answers ACK/NAK and releases the CPU.
module uart_boot_loader
   import soc_pkg::*;
#(
   parameter int         ADDR_WIDTH     = 14,
   parameter logic [7:0] SYNC_BYTE      = BOOT_SYNC_DEFAULT,
   parameter logic [7:0] ACK_BYTE       = BOOT_ACK_DEFAULT,
   parameter logic [7:0] NAK_BYTE       = BOOT_NAK_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 4_800_000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   input  logic                  tx_busy,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   output logic [3:0]            ram_wmask,
   output logic                  cpu_reset_n,
   output logic                  done,
   output logic                  error
);

   localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [32:0] RAM_BYTES = 33'(1) << (ADDR_WIDTH + 2);

   BootState    state;
   BootState    next_state;
   logic [2:0]  hdr_idx;
   logic [31:0] len;
   logic [23:0] base_hi;
   logic [31:0] byte_cnt;
   logic [7:0]  checksum;
   logic [TW-1:0] timer;

   logic [31:0] len_next;
   logic [31:0] base_next;
   logic        frame_start;
   logic        hdr_last;
   logic        hdr_too_long;
   logic        last_data;
   logic        timed_out;
   logic        data_valid;

   assign len_next     = {rx_data, len[31:8]};
   assign base_next    = {rx_data, base_hi};
   assign frame_start  = (state == BootIdle) && rx_valid && (rx_data == SYNC_BYTE);
   assign hdr_last     = (state == BootHeader) && rx_valid && (hdr_idx == 3'd7);
   // Sum form avoids a negative bound when BASE lies beyond the RAM.
   assign hdr_too_long = ({1'b0, len} + {1'b0, base_next}) > RAM_BYTES;
   assign last_data    = (byte_cnt == len - 32'd1);
   assign timed_out    = !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));
   assign data_valid   = (state == BootData) && rx_valid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= BootIdle;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      tx_start   = 1'b0;
      tx_data    = 8'h00;
      case (state)
         BootIdle: begin
            if (frame_start) next_state = BootHeader;
         end
         BootHeader: begin
            if (timed_out) begin
               next_state = BootFail;
            end else if (hdr_last) begin
               if (base_next[1:0] != 2'b00 || hdr_too_long) next_state = BootFail;
               else if (len == 32'd0)                       next_state = BootCheck;
               else                                         next_state = BootData;
            end
         end
         BootData: begin
            if (timed_out)                   next_state = BootFail;
            else if (rx_valid && last_data)  next_state = BootCheck;
         end
         BootCheck: begin
            if (timed_out)     next_state = BootFail;
            else if (rx_valid) next_state = (rx_data == checksum) ? BootAck : BootFail;
         end
         BootAck: begin
            tx_data = ACK_BYTE;
            if (!tx_busy) begin
               tx_start   = 1'b1;
               next_state = BootDone;
            end
         end
         BootFail: begin
            tx_data = NAK_BYTE;
            if (!tx_busy) begin
               tx_start   = 1'b1;
               next_state = BootIdle;
            end
         end
         BootDone: begin
            next_state = BootDone;
         end
         default: next_state = BootIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hdr_idx     <= '0;
         len         <= '0;
         base_hi     <= '0;
         byte_cnt    <= '0;
         checksum    <= '0;
         timer       <= '0;
         error       <= 1'b0;
         done        <= 1'b0;
         cpu_reset_n <= 1'b0;
      end else begin
         case (state)
            BootIdle: begin
               if (frame_start) begin
                  hdr_idx  <= '0;
                  len      <= '0;
                  base_hi  <= '0;
                  byte_cnt <= '0;
                  checksum <= '0;
                  timer    <= '0;
                  error    <= 1'b0;
               end
            end
            BootHeader, BootData, BootCheck: begin
               timer <= rx_valid ? '0 : timer + TW'(1);
               if (rx_valid && state == BootHeader) begin
                  hdr_idx <= hdr_idx + 3'd1;
                  if (!hdr_idx[2]) len     <= len_next;
                  else             base_hi <= base_next[31:8];
               end
               if (data_valid) begin
                  checksum <= checksum + rx_data;
                  byte_cnt <= byte_cnt + 32'd1;
               end
            end
            BootAck: begin
               if (!tx_busy) begin
                  done        <= 1'b1;
                  cpu_reset_n <= 1'b1;
               end
            end
            BootFail: begin
               if (!tx_busy) error <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   boot_word_packer #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_packer (
      .clock      (clock),
      .reset      (reset),
      .start      (frame_start),
      .load_addr  (hdr_last),
      .base_word  (base_next[ADDR_WIDTH+1:2]),
      .byte_valid (data_valid),
      .byte_data  (rx_data),
      .lane       (byte_cnt[1:0]),
      .last       (last_data),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_wmask  (ram_wmask)
   );

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// tb_uart_boot_loader: frame-level model of writes and replies, compared
// against the DUT on every cycle, plus literal spot checks.
module tb_uart_boot_loader;

   localparam int         AW   = 14;
   localparam int         TMO  = 64;
   localparam logic [7:0] SYNC = 8'hA5;
   localparam logic [7:0] ACK  = 8'h4B;
   localparam logic [7:0] NAK  = 8'h45;

   logic          clock    = 1'b0;
   logic          reset    = 1'b0;
   logic [7:0]    rx_data  = 8'h00;
   logic          rx_valid = 1'b0;
   logic          tx_busy  = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [3:0]    ram_wmask;
   logic          cpu_reset_n;
   logic          done;
   logic          error;

   always #5 clock = ~clock;

   uart_boot_loader #(
      .ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .ACK_BYTE(ACK), .NAK_BYTE(NAK), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
      .cpu_reset_n(cpu_reset_n), .done(done), .error(error)
   );

   typedef struct { int due; logic [AW-1:0] addr; logic [31:0] data; logic [3:0] mask; } wr_t;
   typedef struct { int due; logic [7:0] b; } tx_t;

   wr_t exp_wr[$];
   tx_t exp_tx[$];
   int  cyc = 0;
   int  total = 0;
   int  bad = 0;
   int  wr_seen = 0;
   int  wr_before;
   bit  exp_done = 1'b0;
   logic [AW-1:0] last_addr = '0;
   logic [31:0]   last_data = '0;
   logic [3:0]    last_mask = '0;
   logic [7:0]    last_tx = '0;
   logic [7:0]    payload [0:15];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         exp_wr.delete();
         exp_tx.delete();
         exp_done = 1'b0;
      end else begin
         check("done", done, exp_done);
         check("cpu_reset_n", cpu_reset_n, exp_done);
         if (exp_wr.size() > 0 && exp_wr[0].due == cyc) begin
            check("ram_we", ram_we, 1);
            check("ram_addr", ram_addr, exp_wr[0].addr);
            check("ram_wdata", ram_wdata, exp_wr[0].data);
            check("ram_wmask", ram_wmask, exp_wr[0].mask);
            void'(exp_wr.pop_front());
         end else begin
            check("ram_we_idle", ram_we, 0);
         end
         if (ram_we) begin
            wr_seen++;
            last_addr = ram_addr;
            last_data = ram_wdata;
            last_mask = ram_wmask;
         end
         if (tx_busy) begin
            check("tx_start_while_busy", tx_start, 0);
         end else if (exp_tx.size() > 0 && cyc >= exp_tx[0].due) begin
            check("tx_start", tx_start, 1);
            check("tx_data", tx_data, exp_tx[0].b);
            if (exp_tx[0].b == ACK) exp_done = 1'b1;
            void'(exp_tx.pop_front());
         end else begin
            check("tx_start_idle", tx_start, 0);
         end
         if (tx_start) last_tx = tx_data;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output int k);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
      k = cyc;
   endtask

   // Sends one frame and queues what the spec says must come back.
   // nsend < len models a sender that stalls; chk_delta corrupts the checksum.
   task automatic send_frame(input logic [31:0] len, input logic [31:0] base, input int nsend,
                             input int chk_delta, input int gap, input int busy_hold);
      int k;
      logic [7:0]  sum;
      logic [31:0] word;
      logic [3:0]  mask;
      logic [63:0] hdr;
      bit hdr_ok;
      hdr = {base, len};
      send_byte(SYNC, k);
      for (int i = 0; i < 8; i++) send_byte(hdr[8*i +: 8], k);
      hdr_ok = (base[1:0] == 2'b00) && (({32'd0, len} + {32'd0, base}) <= (64'd1 << (AW + 2)));
      if (!hdr_ok) begin
         exp_tx.push_back('{k, NAK});
         tick(8);
      end else begin
         sum = 8'h00; word = '0; mask = '0;
         for (int i = 0; i < nsend; i++) begin
            send_byte(payload[i], k);
            sum += payload[i];
            word[8*(i%4) +: 8] = payload[i];
            mask[i%4] = 1'b1;
            if (i % 4 == 3 || i == int'(len) - 1) begin
               exp_wr.push_back('{k, AW'((base >> 2) + 32'(i / 4)), word, mask});
               word = '0;
               mask = '0;
            end
            tick(gap);
         end
         if (nsend < int'(len)) begin
            exp_tx.push_back('{k + TMO, NAK});
            tick(TMO + 8);
         end else begin
            if (busy_hold > 0) tx_busy = 1'b1;
            send_byte(sum + chk_delta[7:0], k);
            exp_tx.push_back('{k, (chk_delta[7:0] == 8'h00) ? ACK : NAK});
            if (busy_hold > 0) begin
               tick(busy_hold);
               tx_busy = 1'b0;
            end
            tick(8);
         end
      end
      check("wr_queue_drained", exp_wr.size(), 0);
      check("tx_queue_drained", exp_tx.size(), 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
   endtask

   initial begin
      int k;
      reset = 1'b0;
      tick(3);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_wdata", ram_wdata, 0);
      check("rst_ram_wmask", ram_wmask, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_cpu_reset_n", cpu_reset_n, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      reset = 1'b1;
      tick(2);

      for (int i = 0; i < 8; i++) payload[i] = 8'((i + 1) * 8'h11);
      // Checksum forced to 0x00 (true sum is 0x64).
      send_frame(32'd8, 32'h100, 8, 8'h9C, 0, 0);
      check("badchk_error", error, 1);
      check("badchk_cpu_held", cpu_reset_n, 0);
      check("badchk_nak", last_tx, 8'h45);
      send_frame(32'd8, 32'h100, 8, 0, 0, 0);
      check("good_error_clear", error, 0);
      check("good_done", done, 1);
      check("good_cpu_released", cpu_reset_n, 1);
      check("good_ack", last_tx, 8'h4B);
      check("good_last_addr", last_addr, 14'h041);
      check("good_last_data", last_data, 32'h88776655);
      check("good_last_mask", last_mask, 4'hF);

      wr_before = wr_seen;
      send_byte(SYNC, k);
      for (int i = 0; i < 8; i++) send_byte(8'h00, k);
      send_byte(8'h04, k);
      for (int i = 0; i < 4; i++) send_byte(8'h55, k);
      tick(4);
      check("done_ignores_rx", wr_seen, wr_before);

      do_reset();
      payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC;
      send_frame(32'd3, 32'h0, 3, 0, 1, 0);
      check("partial_addr", last_addr, 14'h000);
      check("partial_data", last_data, 32'h00CCBBAA);
      check("partial_mask", last_mask, 4'b0111);
      check("partial_ack", last_tx, 8'h4B);

      do_reset();
      wr_before = wr_seen;
      send_frame(32'd4, 32'h102, 0, 0, 0, 0);
      check("misalign_error", error, 1);
      send_frame(32'h00010001, 32'h0, 0, 0, 0, 0);
      check("toolong_error", error, 1);
      check("hdrfail_no_writes", wr_seen, wr_before);

      for (int i = 0; i < 8; i++) payload[i] = 8'((i + 1) * 8'h11);
      send_frame(32'd8, 32'h0, 2, 0, 0, 0);
      check("timeout_error", error, 1);
      check("timeout_nak", last_tx, 8'h45);

      for (int i = 0; i < 5; i++) payload[i] = 8'(i + 1);
      send_frame(32'd5, 32'hFFEC, 5, 0, 0, 5);
      check("top_error_clear", error, 0);
      check("top_last_addr", last_addr, 14'h3FFC);
      check("top_last_data", last_data, 32'h00000005);
      check("top_last_mask", last_mask, 4'b0001);

      do_reset();
      send_byte(SYNC, k);
      send_byte(8'h08, k);
      for (int i = 0; i < 7; i++) send_byte(8'h00, k);
      for (int i = 0; i < 4; i++) send_byte(8'h77, k);
      check("midreset_write_pending", ram_we, 1);
      reset = 1'b0;
      #1;
      check("midreset_ram_we", ram_we, 0);
      check("midreset_cpu_held", cpu_reset_n, 0);
      check("midreset_done", done, 0);
      tick(2);
      reset = 1'b1;
      tick(1);
      send_frame(32'd0, 32'h0, 0, 0, 0, 0);
      check("len0_done", done, 1);
      check("len0_ack", last_tx, 8'h4B);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
